// File: rtl/syn_gpu_pkg.sv
// Shared types for the GPU job scheduler: job word layout, shape opcodes, dispatch FSM states.
package syn_gpu_pkg;

    localparam int unsigned CANVAS_W = 640;
    localparam int unsigned CANVAS_H = 480;
    localparam int unsigned P_X_W    = $clog2(CANVAS_W);
    localparam int unsigned P_Y_W    = $clog2(CANVAS_H);

    typedef enum logic [1:0] {
        SHAPE_LINE   = 2'd0,
        SHAPE_CIRCLE = 2'd1,
        SHAPE_RSVD2  = 2'd2,
        SHAPE_RSVD3  = 2'd3
    } shape_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pxl_t;

    // Circle jobs carry the centre in x1/y1; x2/y2 meaning is engine-defined.
    typedef struct packed {
        shape_t             shape;
        logic [P_X_W-1:0]   x1;
        logic [P_Y_W-1:0]   y1;
        logic [P_X_W-1:0]   x2;
        logic [P_Y_W-1:0]   y2;
        pxl_t               colour;
        logic [3:0]         width;
    } gpu_job_t;

    localparam int unsigned JOB_W = $bits(gpu_job_t);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LINE,
        WAIT_CIRC
    } gpu_sched_fsm_t;

    function automatic logic is_drawable(input shape_t s);
        return (s == SHAPE_LINE) || (s == SHAPE_CIRCLE);
    endfunction

endpackage

// File: rtl/syn_gpu_job_fifo.sv
// Generic synchronous FIFO with wrapping pointers and an exposed occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must not push when full nor pop when empty.
module syn_gpu_job_fifo #(
    parameter int unsigned P_W     = 8,
    parameter int unsigned P_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [P_W-1:0]             push_dat,
    input  logic                       pop,
    output logic [P_W-1:0]             pop_dat,
    output logic                       empty,
    output logic [$clog2(P_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(P_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [P_W-1:0] mem [P_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/syn_gpu_job_sched.sv
// Round-robin admission of shape jobs from two requesters, queued and dispatched to line/circle engine.
// Latency: accept in N, engine start in N+2; next start 2 cycles after done. Watchdog via SYN_GPU_SCHED_WDOG_EN.
// Backpressure: reqN_ready_o low when not granted or the queue is full (registered count, pops do not free a slot early).
module syn_gpu_job_sched
    import syn_gpu_pkg::*;
#(
    parameter int unsigned P_QDEPTH    = 4,
    parameter int unsigned P_TIMEOUT_W = 16
) (
    input  logic                         clk_ir,
    input  logic                         rst_il,
    input  gpu_job_t                     req0_job_i,
    input  logic                         req0_valid_i,
    output logic                         req0_ready_o,
    input  gpu_job_t                     req1_job_i,
    input  logic                         req1_valid_i,
    output logic                         req1_ready_o,
    output gpu_job_t                     line_job_o,
    output logic                         line_start_o,
    input  logic                         line_done_i,
    output gpu_job_t                     circ_job_o,
    output logic                         circ_start_o,
    input  logic                         circ_done_i,
    output logic                         busy_o,
    output logic [$clog2(P_QDEPTH):0]    qcount_o,
    output logic [7:0]                   drop_cnt_o,
    output logic                         abort_o,
    output logic [7:0]                   tout_cnt_o
);

    localparam int unsigned CW = $clog2(P_QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(P_QDEPTH);

    gpu_sched_fsm_t state_q;
    gpu_sched_fsm_t state_nxt;

    logic           last_gnt;
    logic           gnt0;
    logic           gnt1;
    logic           room;
    logic           push;
    gpu_job_t       push_dat;
    logic           pop;
    logic           q_empty;
    logic [CW-1:0]  qcount;
    gpu_job_t       head_dat;
    shape_t         issue_shape_q;
    logic           drop;

`ifdef SYN_GPU_SCHED_WDOG_EN
    localparam logic [P_TIMEOUT_W-1:0] WDOG_ONE  = {{(P_TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [P_TIMEOUT_W-1:0] WDOG_LAST = {{(P_TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [P_TIMEOUT_W-1:0] wdog_q;
    logic                   wdog_hit;
    logic                   expire;
    // The count holds k-1 in the k-th wait cycle, so it becomes all-ones as that cycle ends.
    assign wdog_hit = (wdog_q == WDOG_LAST);
`endif

    // last_gnt = 1 means requester 1 won the last accepted transfer.
    assign gnt0 = req0_valid_i & (~req1_valid_i | last_gnt);
    assign gnt1 = req1_valid_i & (~req0_valid_i | ~last_gnt);
    assign room = (qcount < QDEPTH_C);

    assign req0_ready_o = gnt0 & room;
    assign req1_ready_o = gnt1 & room;
    assign push         = req0_ready_o | req1_ready_o;
    assign push_dat     = req1_ready_o ? req1_job_i : req0_job_i;

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            last_gnt <= 1'b1;
        end else if (push) begin
            last_gnt <= req1_ready_o;
        end
    end

    syn_gpu_job_fifo #(
        .P_W     (JOB_W),
        .P_DEPTH (P_QDEPTH)
    ) u_fifo (
        .clk      (clk_ir),
        .rst_n    (rst_il),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .empty    (q_empty),
        .count    (qcount)
    );

    assign qcount_o = qcount;

    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
        drop      = 1'b0;
`ifdef SYN_GPU_SCHED_WDOG_EN
        expire    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                case (issue_shape_q)
                    SHAPE_LINE:   state_nxt = WAIT_LINE;
                    SHAPE_CIRCLE: state_nxt = WAIT_CIRC;
                    default: begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end
                endcase
            end
            WAIT_LINE: begin
                if (line_done_i) begin
                    state_nxt = IDLE;
                end
`ifdef SYN_GPU_SCHED_WDOG_EN
                else if (wdog_hit) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            WAIT_CIRC: begin
                if (circ_done_i) begin
                    state_nxt = IDLE;
                end
`ifdef SYN_GPU_SCHED_WDOG_EN
                else if (wdog_hit) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Engine job/start registers load at the pop edge so the start pulse coincides with ISSUE.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q       <= IDLE;
            issue_shape_q <= SHAPE_LINE;
            line_job_o    <= '0;
            line_start_o  <= 1'b0;
            circ_job_o    <= '0;
            circ_start_o  <= 1'b0;
            drop_cnt_o    <= 8'd0;
            busy_o        <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            busy_o       <= push | (state_nxt != IDLE) | (qcount != '0);
            line_start_o <= pop && (head_dat.shape == SHAPE_LINE);
            circ_start_o <= pop && (head_dat.shape == SHAPE_CIRCLE);
            if (pop) begin
                issue_shape_q <= head_dat.shape;
            end
            if (pop && (head_dat.shape == SHAPE_LINE)) begin
                line_job_o <= head_dat;
            end
            if (pop && (head_dat.shape == SHAPE_CIRCLE)) begin
                circ_job_o <= head_dat;
            end
            if (drop && (drop_cnt_o != 8'hFF)) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

`ifdef SYN_GPU_SCHED_WDOG_EN
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            wdog_q     <= '0;
            abort_o    <= 1'b0;
            tout_cnt_o <= 8'd0;
        end else begin
            if (state_q == ISSUE) begin
                wdog_q <= '0;
            end else if ((state_q == WAIT_LINE) || (state_q == WAIT_CIRC)) begin
                wdog_q <= wdog_q + WDOG_ONE;
            end
            abort_o <= expire;
            if (expire && (tout_cnt_o != 8'hFF)) begin
                tout_cnt_o <= tout_cnt_o + 8'd1;
            end
        end
    end
`else
    assign abort_o    = 1'b0;
    assign tout_cnt_o = 8'd0;
    // Timeout width only sizes the watchdog; without it there is nothing to build.
    if (P_TIMEOUT_W == 0) begin : g_no_wdog
    end
`endif

endmodule
